text_pixel_render: RTL and testbench
====================================

Name: text_pixel_render

Overview:
Downstream stage of the character-cell fetch. Takes raster pixel coordinates from the VGA timing block and drives the character-cell address (column/line) into the text-area fetch. It consumes the returned ASCII/colour pair, looks up the glyph row in an external synchronous font ROM, and emits one registered RGB332 pixel per clock. It also overlays a blinking underline cursor and delays the sync signals so they stay aligned with the pixel data.

Parameters:
COLS, 80, number of text columns; cells with col >= COLS render as background
ROWS, 30, number of text lines; cells with line >= ROWS render as background
BLINK_FRAMES, 30, frames per cursor blink half-period (1..63)

Ports:
clk  in  1  pixel clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
pixel_x  in  10  current raster column
pixel_y  in  10  current raster line
video_on  in  1  active-video qualifier for pixel_x/pixel_y
hsync_in  in  1  horizontal sync from timing block (active low)
vsync_in  in  1  vertical sync from timing block (active low)
HorzPos  out  7  character column = pixel_x[9:3], combinational
LineCount  out  6  character line = pixel_y[9:4], combinational
ASCII  in  8  character code, valid 1 clk after HorzPos/LineCount
TextColor  in  8  foreground RGB332, valid with ASCII
font_addr  out  12  {ASCII[6:0], glyph_row[3:0]}, registered
font_row  in  8  glyph bits, valid 1 clk after font_addr; bit7 = leftmost pixel
cursor_col  in  7  cursor column
cursor_row  in  6  cursor line
cursor_en  in  1  cursor overlay enable
rgb  out  8  RGB332 pixel, registered
hsync_out  out  1  hsync_in delayed 3 clk
vsync_out  out  1  vsync_in delayed 3 clk

Behaviour:
- Cell geometry is 8x16. glyph_col = pixel_x[2:0]; glyph_row = pixel_y[3:0].
- Pipeline. Coordinates are presented at cycle T.
  - S1 (T+1): register glyph_col, glyph_row, video_on, in-range flag, cursor-hit flag and syncs; ASCII/TextColor arrive.
  - S2 (T+2): font_addr registered from ASCII and S1 glyph_row; register TextColor, ASCII[7] (inverse flag) and the S1 side-band; font_row arrives at the end of S2.
  - S3 (T+3): rgb registered.
  - Total latency 3 clk from pixel_x/pixel_y to rgb. hsync/vsync pass through the same 3 stages.
- In-range flag: (pixel_x[9:3] < COLS) && (pixel_y[9:4] < ROWS), evaluated at T.
- Pixel bit: font_row[7 - glyph_col].
- Cursor hit: cursor_en && blink_phase && col==cursor_col && line==cursor_row && glyph_row >= 14. A hit forces the pixel bit to 1.
- Colour: fg = TextColor, bg = 8'h00. If ASCII[7]=1, fg and bg are swapped (inverse video), applied after the cursor force.
- rgb = 8'h00 when the delayed video_on=0 or the in-range flag=0. Otherwise rgb = pixel bit ? fg : bg.
- Blink counter:
  - A falling edge of the S1-registered vsync increments frame_cnt (6 bits).
  - When frame_cnt reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - The counter runs whether or not cursor_en is set.
- Reset (synchronous) clears all pipeline registers:
  - rgb=0, font_addr=0, video_on pipe=0
  - hsync_out=1, vsync_out=1 (inactive), sync pipe=1
  - frame_cnt=0, blink_phase=1
- Reset asserted mid-frame:
  - outputs take their reset values on the next edge;
  - the first valid rgb appears 3 clk after rst deasserts with video_on=1.
- No stall path: the pipeline advances every clock, and inputs must be valid every cycle.
- HorzPos/LineCount are a pure slice of the inputs, carrying no state. They are valid even when video_on=0, so prefetch during blanking is harmless.

Test Plan:
- Reset: hold rst 2 clk with syncs low -> rgb=00, hsync_out=vsync_out=1, font_addr=000. After release the sync outputs follow the inputs exactly 3 clk later.
- Glyph render: cell (0,0) has ASCII=8'h41, TextColor=8'hE0; font model returns 8'b0001_1000 for row 0; sweep x=0..7, y=0 -> rgb sequence 00,00,00,E0,E0,00,00,00, each 3 clk after its x. font_addr=12'h410 at T+2.
- Inverse video: ASCII=8'hC1, same colour and font -> rgb E0,E0,E0,00,00,E0,E0,E0.
- Range and blanking: pixel_x=640 (col 80) with video_on=1 -> rgb=00. video_on=0 at an in-range pixel with a lit bit -> rgb=00.
- Cursor blink: cursor at (5,2), cursor_en=1, blank glyph, TextColor=8'h1C; y=46 (row 14), x=40..47 -> rgb=1C for all 8 pixels while phase=1. Apply 30 vsync falling edges -> phase=0, rgb=00. 30 more edges -> rgb=1C again. At y=45 (row 13) rgb stays 00.
- Back-to-back cells: continuous x=0..15 across two characters with different colours -> colour changes exactly at the cell boundary with no bubble or duplicated pixel.

Source files
------------

// File: rtl/text_pixel_render.sv
// Text-mode pixel renderer: character-cell addressing, font lookup, cursor overlay
// and a 3-stage pixel pipeline with sync signals delayed to match.
module text_pixel_render #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [6:0]  HorzPos,
  output logic [5:0]  LineCount,
  input  logic [7:0]  ASCII,
  input  logic [7:0]  TextColor,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_row,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  input  logic        cursor_en,
  output logic [7:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [7:0] COLS_L     = 8'(COLS);
  localparam logic [6:0] ROWS_L     = 7'(ROWS);
  localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

  logic       in_range, cursor_hit;
  logic [2:0] gcol1, gcol2;
  logic [3:0] grow1;
  logic       von1, inr1, cur1, hs1, vs1;
  logic       von2, inr2, cur2, hs2, vs2, inv2;
  logic [7:0] color2;
  logic [5:0] frame_cnt;
  logic       blink_phase;
  logic [2:0] bit_sel;
  logic       pix_bit;
  logic [7:0] rgb_next;

  assign HorzPos   = pixel_x[9:3];
  assign LineCount = pixel_y[9:4];

  always_comb begin
    in_range   = ({1'b0, pixel_x[9:3]} < COLS_L) && ({1'b0, pixel_y[9:4]} < ROWS_L);
    cursor_hit = cursor_en && blink_phase
                 && (pixel_x[9:3] == cursor_col) && (pixel_y[9:4] == cursor_row)
                 && (pixel_y[3:0] >= 4'd14);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gcol1 <= '0;
      grow1 <= '0;
      von1  <= 1'b0;
      inr1  <= 1'b0;
      cur1  <= 1'b0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
    end else begin
      gcol1 <= pixel_x[2:0];
      grow1 <= pixel_y[3:0];
      von1  <= video_on;
      inr1  <= in_range;
      cur1  <= cursor_hit;
      hs1   <= hsync_in;
      vs1   <= vsync_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      font_addr <= '0;
      color2    <= '0;
      inv2      <= 1'b0;
      gcol2     <= '0;
      von2      <= 1'b0;
      inr2      <= 1'b0;
      cur2      <= 1'b0;
      hs2       <= 1'b1;
      vs2       <= 1'b1;
    end else begin
      font_addr <= {1'b0, ASCII[6:0], grow1};
      color2    <= TextColor;
      inv2      <= ASCII[7];
      gcol2     <= gcol1;
      von2      <= von1;
      inr2      <= inr1;
      cur2      <= cur1;
      hs2       <= hs1;
      vs2       <= vs1;
    end
  end

  // vs2 is vs1 one clock later, so (vs2 & ~vs1) marks the falling edge of the S1 vsync.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (vs2 && !vs1) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

  // ~gcol equals 7-gcol for a 3-bit column: bit7 is the leftmost glyph pixel.
  // Inverse video swaps fg/bg after the cursor force, i.e. flips the selected bit.
  always_comb begin
    bit_sel  = ~gcol2;
    pix_bit  = font_row[bit_sel] | cur2;
    rgb_next = (von2 && inr2 && (pix_bit ^ inv2)) ? color2 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb       <= rgb_next;
      hsync_out <= hs2;
      vsync_out <= vs2;
    end
  end

endmodule

// File: tb/tb_text_pixel_render.sv
// Directed bench for text_pixel_render: text RAM and font ROM models feed the DUT,
// each pixel's hand-computed rgb and sync values are compared three clocks later.
module tb_text_pixel_render;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, hsync_in, vsync_in;
  logic [6:0]  HorzPos;
  logic [5:0]  LineCount;
  logic [7:0]  ascii, text_color;
  logic [11:0] font_addr;
  logic [7:0]  font_row;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        cursor_en;
  logic [7:0]  rgb;
  logic        hsync_out, vsync_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] txt_ascii [0:127];
  logic [7:0] txt_color [0:127];

  logic [7:0] p_exp [3];
  logic       p_hs  [3];
  logic       p_vs  [3];
  bit         p_chk [3];
  bit         p_val [3];
  string      p_tag [3];

  logic [7:0] exp_a   [8]  = '{8'h00, 8'h00, 8'h00, 8'hE0, 8'hE0, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_inv [8]  = '{8'hE0, 8'hE0, 8'hE0, 8'h00, 8'h00, 8'hE0, 8'hE0, 8'hE0};
  logic [7:0] exp_b2b [16] = '{8'h00, 8'h00, 8'h00, 8'hE0, 8'hE0, 8'h00, 8'h00, 8'h00,
                               8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};

  text_pixel_render #(.COLS(80), .ROWS(30), .BLINK_FRAMES(30)) dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .HorzPos(HorzPos), .LineCount(LineCount),
    .ASCII(ascii), .TextColor(text_color), .font_addr(font_addr), .font_row(font_row),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  // Text area: one-clock registered read, indexed by column only.
  always @(posedge clk) begin
    ascii      <= txt_ascii[HorzPos];
    text_color <= txt_color[HorzPos];
  end

  // Font ROM: the address register is font_addr itself; data follows it.
  always_comb begin
    case (font_addr[10:4])
      7'h41:   font_row = 8'b0001_1000;
      7'h7F:   font_row = 8'hFF;
      default: font_row = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int x, input int y, input logic v, input logic hs,
                      input logic vs, input bit chk, input logic [7:0] exp, input string tag);
    @(negedge clk);
    if (p_val[2]) begin
      if (p_chk[2]) check(p_tag[2], {4'h0, rgb}, {4'h0, p_exp[2]});
      check("hsync_out", {11'h0, hsync_out}, {11'h0, p_hs[2]});
      check("vsync_out", {11'h0, vsync_out}, {11'h0, p_vs[2]});
    end
    for (int i = 2; i > 0; i--) begin
      p_exp[i] = p_exp[i-1]; p_hs[i] = p_hs[i-1]; p_vs[i] = p_vs[i-1];
      p_chk[i] = p_chk[i-1]; p_val[i] = p_val[i-1]; p_tag[i] = p_tag[i-1];
    end
    p_exp[0] = exp; p_hs[0] = hs; p_vs[0] = vs; p_chk[0] = chk; p_val[0] = 1'b1; p_tag[0] = tag;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = v;
    hsync_in = hs;
    vsync_in = vs;
  endtask

  task automatic flush();
    repeat (3) step(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "");
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    check("rst_rgb",       {4'h0, rgb},        12'h000);
    check("rst_hsync",     {11'h0, hsync_out}, 12'h001);
    check("rst_vsync",     {11'h0, vsync_out}, 12'h001);
    check("rst_font_addr", font_addr,          12'h000);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) p_val[i] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      txt_ascii[i] = 8'h00;
      txt_color[i] = 8'h00;
    end
    for (int i = 0; i < 3; i++) p_val[i] = 1'b0;
    pixel_x = '0; pixel_y = '0; video_on = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0;
    cursor_col = 7'd5; cursor_row = 6'd2; cursor_en = 1'b0;

    // Reset with syncs low, then syncs must follow the inputs three clocks later.
    do_reset(2);
    for (int i = 0; i < 8; i++)
      step(0, 0, 1'b1, 1'(i), 1'(i >> 1), 1'b1, 8'h00, "idle");
    flush();

    // Glyph row of 'A' in red, then steady cell (0,0) for the font address.
    txt_ascii[0] = 8'h41; txt_color[0] = 8'hE0;
    for (int x = 0; x < 8; x++) step(x, 0, 1'b1, 1'b1, 1'b1, 1'b1, exp_a[x], "glyph");
    repeat (4) step(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "");
    check("font_addr", font_addr, 12'h410);
    flush();

    // Inverse video.
    txt_ascii[0] = 8'hC1;
    for (int x = 0; x < 8; x++) step(x, 0, 1'b1, 1'b1, 1'b1, 1'b1, exp_inv[x], "inverse");
    flush();

    // Back-to-back cells with different colours.
    txt_ascii[0] = 8'h41; txt_color[0] = 8'hE0;
    txt_ascii[1] = 8'h7F; txt_color[1] = 8'h03;
    for (int x = 0; x < 16; x++) step(x, 0, 1'b1, 1'b1, 1'b1, 1'b1, exp_b2b[x], "b2b");
    flush();

    // Range and blanking.
    txt_ascii[80] = 8'h7F; txt_color[80] = 8'hFF;
    step(3,   0,   1'b1, 1'b1, 1'b1, 1'b1, 8'hE0, "lit");
    step(640, 0,   1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "col80");
    step(3,   480, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "line30");
    step(3,   0,   1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "blank");
    step(4,   0,   1'b1, 1'b1, 1'b1, 1'b1, 8'hE0, "lit2");
    flush();

    // Reset mid-stream while lit pixels are in flight.
    repeat (3) step(3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "");
    do_reset(1);
    step(3, 0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hE0, "post_rst");
    flush();

    // Cursor blink on a blank glyph.
    txt_ascii[5] = 8'h20; txt_color[5] = 8'h1C;
    cursor_en = 1'b1;
    for (int x = 40; x < 48; x++) step(x, 46, 1'b1, 1'b1, 1'b1, 1'b1, 8'h1C, "cursor_on");
    for (int x = 40; x < 48; x++) step(x, 45, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "cursor_row13");
    flush();
    repeat (30) begin
      step(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "");
      step(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "");
    end
    for (int x = 40; x < 48; x++) step(x, 46, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "cursor_off");
    flush();
    repeat (30) begin
      step(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "");
      step(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "");
    end
    for (int x = 40; x < 48; x++) step(x, 46, 1'b1, 1'b1, 1'b1, 1'b1, 8'h1C, "cursor_on2");
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
